toggle_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit toggle register among NREQ requesters. Each requester presents a toggle mask. The block grants one requester at a time, latches its mask, and pulses the mask onto the T inputs of the shared register, so `q <= q ^ mask`. It sits between independent control agents and a common toggle-flip-flop state register, and serialises their updates so that no toggle is lost or doubled.

---
 rtl/toggle_arbiter_pkg.sv | 47 ++++
 rtl/toggle_arbiter_rr_pick.sv | 32 +++
 rtl/toggle_arbiter.sv | 110 +++++++++++
 tb/tb_toggle_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_arbiter_pkg.sv
// Shared types and helpers for toggle_arbiter: FSM state encoding and winner selection.
// Optional build macro: TOGGLE_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
package toggle_arb_pkg;

  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_NREQ      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Search starts at ptr and wraps modulo nreq; the first set request wins.
  function automatic logic [MAX_NREQ-1:0] rr_onehot(input logic [MAX_NREQ-1:0] req,
                                                    input logic [2:0]          ptr,
                                                    input int                  nreq);
    logic [MAX_NREQ-1:0] win;
    logic                found;
    logic [2:0]          pos;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      pos = 3'((int'(ptr) + k) % nreq);
      if (!found && (k < nreq) && req[pos]) begin
        win[pos] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [MAX_NREQ-1:0] lowest_onehot(input logic [MAX_NREQ-1:0] req);
    return req & (~req + 1'b1);
  endfunction

  function automatic logic [2:0] onehot_index(input logic [MAX_NREQ-1:0] win);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (win[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/toggle_arbiter_rr_pick.sv
// Combinational winner selector for toggle_arbiter: one-hot winner plus its index.
// Under TOGGLE_ARB_FIXED_PRIO_EN it becomes a lowest-index priority encoder with no ptr input.
module rr_pick
  import toggle_arb_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
`ifndef TOGGLE_ARB_FIXED_PRIO_EN
  input  logic [PW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx
);

  logic [MAX_NREQ-1:0] req_ext;
  logic [MAX_NREQ-1:0] win_ext;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
`ifdef TOGGLE_ARB_FIXED_PRIO_EN
    win_ext = lowest_onehot(req_ext);
`else
    win_ext = rr_onehot(req_ext, 3'(ptr), NREQ);
`endif
    win = win_ext[NREQ-1:0];
    idx = PW'(onehot_index(win_ext));
  end

endmodule

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter that serialises toggle masks from NREQ agents onto one shared toggle register.
// Build macro TOGGLE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and removes ptr.
module toggle_arbiter
  import toggle_arb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] t;
  logic [NREQ-1:0]  win;
  logic [PW-1:0]    win_idx;

`ifndef TOGGLE_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;

  assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (req),
`ifndef TOGGLE_ARB_FIXED_PRIO_EN
    .ptr  (ptr),
`endif
    .win  (win),
    .idx  (win_idx)
  );

  // Winner's mask slice picked by the one-hot vector, avoiding a variable part-select.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) sel_mask = sel_mask | mask[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      mask_r <= '0;
      busy   <= 1'b0;
`ifndef TOGGLE_ARB_FIXED_PRIO_EN
      ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= GRANT;
            gnt    <= win;
            mask_r <= sel_mask;
            busy   <= 1'b1;
`ifndef TOGGLE_ARB_FIXED_PRIO_EN
            ptr    <= ptr_next;
`endif
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          state <= APPLY;
          gnt   <= '0;
        end
        APPLY: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The T inputs see the latched mask only during APPLY, so q moves on APPLY's closing edge alone.
  always_comb begin
    t = '0;
    if (state == APPLY) t = mask_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q ^ t;
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_in_grant: assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> (state == GRANT));
  a_q_only_apply: assert property (@(posedge clk) disable iff (rst) (state != APPLY) |=> $stable(q));

endmodule

// File: tb/tb_toggle_arbiter.sv
// Self-checking bench for toggle_arbiter (default round-robin build, NREQ=4, WIDTH=8):
// directed vector table, then randomized traffic against a countdown-based reference model.
module tb_toggle_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;

  toggle_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mask (mask),
    .gnt  (gnt),
    .q    (q),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  r;
    logic [NREQ-1:0]       rq;
    logic [NREQ*WIDTH-1:0] mk;
    logic [NREQ-1:0]       g;
    logic [WIDTH-1:0]      qv;
    logic                  b;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a transaction is a countdown of remaining busy edges plus a pending toggle.
  int               m_remain;
  int               m_ptr;
  logic [NREQ-1:0]  m_gnt;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_pend;

  function automatic void model_reset();
    m_remain = 0;
    m_ptr    = 0;
    m_gnt    = '0;
    m_q      = '0;
    m_pend   = '0;
  endfunction

  function automatic void model_step(input logic r, input logic [NREQ-1:0] rq,
                                     input logic [NREQ*WIDTH-1:0] mk);
    if (r) begin
      model_reset();
      return;
    end
    m_gnt = '0;
    if (m_remain > 0) begin
      m_remain--;
      if (m_remain == 0) m_q = m_q ^ m_pend;
    end else if (rq != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int w;
        w = (m_ptr + k) % NREQ;
        if (rq[w]) begin
          m_gnt[w] = 1'b1;
          m_pend   = mk[w*WIDTH +: WIDTH];
          m_ptr    = (w + 1) % NREQ;
          break;
        end
      end
      m_remain = 2;
    end
  endfunction

  function automatic void add(input logic r, input logic [NREQ-1:0] rq,
                              input logic [NREQ*WIDTH-1:0] mk, input logic [NREQ-1:0] g,
                              input logic [WIDTH-1:0] qv, input logic b);
    vec_t v;
    v.r = r; v.rq = rq; v.mk = mk; v.g = g; v.qv = qv; v.b = b;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq,
                               input logic [NREQ*WIDTH-1:0] mk);
    rst  = r;
    req  = rq;
    mask = mk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [NREQ-1:0] eg,
                             input logic [WIDTH-1:0] eq, input logic eb);
    vectors++;
    if (gnt !== eg || q !== eq || busy !== eb) begin
      miscompares++;
      $display("[TB] FAIL %s: got gnt=%b q=%h busy=%b, expected gnt=%b q=%h busy=%b",
               name, gnt, q, busy, eg, eq, eb);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d grants, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int               grants[NREQ];
    logic             r;
    logic [NREQ-1:0]  rq;
    logic [NREQ*WIDTH-1:0] mk;

    rst  = 1'b1;
    req  = '0;
    mask = '0;
    #1;
    checkOutput("async_reset", 4'b0000, 8'h00, 1'b0);

    // Idle after reset.
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 32'h0, 4'b0000, 8'h00, 0);
    // Single requester 0, mask A5, twice.
    add(0, 4'b0001, 32'h000000A5, 4'b0001, 8'h00, 1);
    add(0, 4'b0000, 32'h000000A5, 4'b0000, 8'h00, 1);
    add(0, 4'b0000, 32'h000000A5, 4'b0000, 8'hA5, 0);
    add(0, 4'b0001, 32'h000000A5, 4'b0001, 8'hA5, 1);
    add(0, 4'b0000, 32'h000000A5, 4'b0000, 8'hA5, 1);
    add(0, 4'b0000, 32'h000000A5, 4'b0000, 8'h00, 0);
    // All four at once after reset: order 0,1,2,3 at 3-cycle spacing.
    add(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0);
    add(0, 4'b1111, 32'h08040201, 4'b0001, 8'h00, 1);
    add(0, 4'b1110, 32'h08040201, 4'b0000, 8'h00, 1);
    add(0, 4'b1110, 32'h08040201, 4'b0000, 8'h01, 0);
    add(0, 4'b1110, 32'h08040201, 4'b0010, 8'h01, 1);
    add(0, 4'b1100, 32'h08040201, 4'b0000, 8'h01, 1);
    add(0, 4'b1100, 32'h08040201, 4'b0000, 8'h03, 0);
    add(0, 4'b1100, 32'h08040201, 4'b0100, 8'h03, 1);
    add(0, 4'b1000, 32'h08040201, 4'b0000, 8'h03, 1);
    add(0, 4'b1000, 32'h08040201, 4'b0000, 8'h07, 0);
    add(0, 4'b1000, 32'h08040201, 4'b1000, 8'h07, 1);
    add(0, 4'b0000, 32'h08040201, 4'b0000, 8'h07, 1);
    add(0, 4'b0000, 32'h08040201, 4'b0000, 8'h0F, 0);
    // Reset during APPLY of an FF transaction, then a clean FF transaction.
    add(0, 4'b0001, 32'h000000FF, 4'b0001, 8'h0F, 1);
    add(0, 4'b0000, 32'h000000FF, 4'b0000, 8'h0F, 1);
    add(1, 4'b0000, 32'h000000FF, 4'b0000, 8'h00, 0);
    add(0, 4'b0001, 32'h000000FF, 4'b0001, 8'h00, 1);
    add(0, 4'b0000, 32'h000000FF, 4'b0000, 8'h00, 1);
    add(0, 4'b0000, 32'h000000FF, 4'b0000, 8'hFF, 0);
    // Zero mask from requester 2, then 1 and 3 together: ptr=3 picks 3, then 1.
    add(0, 4'b0100, 32'h00000000, 4'b0100, 8'hFF, 1);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 8'hFF, 1);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 8'hFF, 0);
    add(0, 4'b1010, 32'h22001100, 4'b1000, 8'hFF, 1);
    add(0, 4'b0010, 32'h22001100, 4'b0000, 8'hFF, 1);
    add(0, 4'b0010, 32'h22001100, 4'b0000, 8'hDD, 0);
    add(0, 4'b0010, 32'h22001100, 4'b0010, 8'hDD, 1);
    add(0, 4'b0000, 32'h22001100, 4'b0000, 8'hDD, 1);
    add(0, 4'b0000, 32'h22001100, 4'b0000, 8'hCC, 0);
    // Mask changed after the grant edge has no effect.
    add(0, 4'b0001, 32'h0000000F, 4'b0001, 8'hCC, 1);
    add(0, 4'b0000, 32'h000000F0, 4'b0000, 8'hCC, 1);
    add(0, 4'b0000, 32'h000000F0, 4'b0000, 8'hC3, 0);
    // req held high through the transaction becomes a new request.
    add(0, 4'b0100, 32'h003C0000, 4'b0100, 8'hC3, 1);
    add(0, 4'b0100, 32'h003C0000, 4'b0000, 8'hC3, 1);
    add(0, 4'b0100, 32'h003C0000, 4'b0000, 8'hFF, 0);
    add(0, 4'b0100, 32'h003C0000, 4'b0100, 8'hFF, 1);
    add(0, 4'b0000, 32'h003C0000, 4'b0000, 8'hFF, 1);
    add(0, 4'b0000, 32'h003C0000, 4'b0000, 8'hC3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].rq, vecs[i].mk);
      checkOutput($sformatf("vec%0d", i), vecs[i].g, vecs[i].qv, vecs[i].b);
    end

    // Randomized traffic with occasional resets.
    applyStimulus(1'b1, '0, '0);
    model_reset();
    checkOutput("rand_reset", m_gnt, m_q, m_remain > 0);
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rq = '0;
      mk = $urandom;
      applyStimulus(r, rq, mk);
      model_step(r, rq, mk);
      checkOutput($sformatf("rand%0d", c), m_gnt, m_q, m_remain > 0);
    end

    // Fairness: all requesting continuously for two full rounds.
    applyStimulus(1'b1, '0, '0);
    model_reset();
    checkOutput("fair_reset", m_gnt, m_q, m_remain > 0);
    for (int i = 0; i < NREQ; i++) grants[i] = 0;
    mk = $urandom;
    for (int c = 0; c < 6 * NREQ; c++) begin
      applyStimulus(1'b0, 4'b1111, mk);
      model_step(1'b0, 4'b1111, mk);
      checkOutput($sformatf("fair%0d", c), m_gnt, m_q, m_remain > 0);
      for (int i = 0; i < NREQ; i++) if (gnt[i]) grants[i]++;
    end
    for (int i = 0; i < NREQ; i++) checkCount($sformatf("fair_count%0d", i), grants[i], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
